// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the dmem arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // 4096 words = 16 KB of data memory
  localparam int unsigned DEFAULT_WORD_TOP = 32'd4095;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester priority pick, one-hot grant {b, a}
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       prio,
  output logic [1:0] grant
);

  // A wins when alone or when it holds priority; otherwise B if it asks
  always_comb begin
    grant = 2'b00;
    if (req_a && (!req_b || (prio == PORT_A))) begin
      grant = 2'b01;
    end else if (req_b) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port sequencer for single-port dmem; optional range check under DMEM_ARB_BOUNDS_EN
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned WORD_TOP   = DEFAULT_WORD_TOP,
  parameter logic        RESET_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_we,
  input  logic        a_lock,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_we,
  input  logic        b_lock,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  arb_state_t  state_q, state_d;
  logic        prio_q;
  logic        owner_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  we_q;
  logic        lock_q;
  logic        oob_q;
  logic [31:0] rdata_q;

  logic [1:0]  grant;
  logic        win_b;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_we;
  logic        win_lock;
  logic        win_oob;

  // byte offset bits never reach the word-addressed memory
  logic        unused_ok;
  assign unused_ok = ^{a_addr[1:0], b_addr[1:0]};

  rr_arb2 u_rr_arb2 (
    .req_a (a_req),
    .req_b (b_req),
    .prio  (prio_q),
    .grant (grant)
  );

  assign win_b     = grant[1];
  assign win_addr  = win_b ? b_addr  : a_addr;
  assign win_wdata = win_b ? b_wdata : a_wdata;
  assign win_we    = win_b ? b_we    : a_we;
  assign win_lock  = win_b ? b_lock  : a_lock;

`ifdef DMEM_ARB_BOUNDS_EN
  assign win_oob = ({2'b00, win_addr[31:2]} > WORD_TOP);
`else
  assign win_oob = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // fixed IDLE -> ACCESS -> RESP sequence; memory strobes and acks decoded from state
  always_comb begin
    state_d = state_q;
    dwe     = 4'h0;
    a_ack   = 1'b0;
    b_ack   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) state_d = ACCESS;
      end
      ACCESS: begin
        // reset in this cycle must not corrupt memory
        if (!reset && !oob_q) dwe = we_q;
        state_d = RESP;
      end
      RESP: begin
        a_ack   = (owner_q == PORT_A);
        b_ack   = (owner_q == PORT_B);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // request latch on grant, read capture in ACCESS, priority hand-off leaving RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q  <= RESET_PRIO;
      owner_q <= PORT_A;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      lock_q  <= 1'b0;
      oob_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            owner_q <= win_b;
            addr_q  <= win_addr[31:2];
            wdata_q <= win_wdata;
            we_q    <= win_we;
            lock_q  <= win_lock;
            oob_q   <= win_oob;
          end
        end
        ACCESS: begin
          // drdata is combinational, so a write still returns the old word
          rdata_q <= oob_q ? 32'h0 : drdata;
        end
        RESP: begin
          prio_q <= lock_q ? owner_q : ~owner_q;
        end
        default: ;
      endcase
    end
  end

  assign daddr   = {addr_q, 2'b00};
  assign dwdata  = wdata_q;
  assign a_rdata = rdata_q;
  assign b_rdata = rdata_q;

`ifdef DMEM_ARB_BOUNDS_EN
  assign a_err = a_ack && oob_q;
  assign b_err = b_ack && oob_q;
`else
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural dmem
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, b_req, a_lock, b_lock;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic [3:0]  a_we, b_we;
  logic        a_ack, b_ack, a_err, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dwe;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        mon_p;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] mem [4096] = '{default: 32'h0};

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we), .a_lock(a_lock),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we), .b_lock(b_lock),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign drdata = mem[daddr[13:2]];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (dwe[i]) mem[daddr[13:2]][8*i +: 8] <= dwdata[8*i +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (a_ack && b_ack) begin
      check("dual_ack", {a_ack, b_ack}, 2'b01);
    end else if (a_ack || b_ack) begin
      mon_p = b_ack;
      if (sb.size() == 0) begin
        check("unexpected_ack", {31'b0, mon_p}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("ack_port",  {31'b0, mon_p}, {31'b0, mon_e.port});
        check("ack_cycle", cyc, mon_e.cyc);
        check("rdata",     mon_p ? b_rdata : a_rdata, mon_e.data);
        check("err",       {31'b0, mon_p ? b_err : a_err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic r, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [3:0] w, input logic lk);
    if (p) begin
      b_req = r; b_addr = ad; b_wdata = wd; b_we = w; b_lock = lk;
    end else begin
      a_req = r; a_addr = ad; a_wdata = wd; a_we = w; a_lock = lk;
    end
  endtask

  task automatic expect_ack(input logic p, input logic [31:0] d, input logic e, input int c);
    exp_t x;
    x.port = p; x.data = d; x.err = e; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic single(input logic p, input logic [31:0] ad, input logic [31:0] wd,
                        input logic [3:0] w, input logic [31:0] d, input logic e);
    int   c0;
    logic got;
    c0  = cyc;
    got = 1'b0;
    drive(p, 1'b1, ad, wd, w, 1'b0);
    expect_ack(p, d, e, c0 + 2);
    for (int i = 0; i < 8 && !got; i++) begin
      tick(1);
      got = p ? b_ack : a_ack;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    drive(p, 1'b0, ad, wd, w, 1'b0);
    tick(1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"},    {24'b0, a_ack, b_ack, a_err, b_err, dwe}, 32'h0);
    check({tag, "_rdata"},  a_rdata | b_rdata, 32'h0);
    check({tag, "_daddr"},  daddr, 32'h0);
    check({tag, "_dwdata"}, dwdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick(2);
    reset = 1'b0;
    check_zero("reset");

    // single write then read-back, byte write, address low bits ignored
    single(1'b0, 32'h10,   32'hDEADBEEF, 4'hF,    32'h0,        1'b0);
    single(1'b0, 32'h10,   32'h0,        4'h0,    32'hDEADBEEF, 1'b0);
    single(1'b0, 32'h30,   32'h11223344, 4'hF,    32'h0,        1'b0);
    single(1'b1, 32'h30,   32'h0000AB00, 4'b0010, 32'h11223344, 1'b0);
    single(1'b0, 32'h30,   32'h0,        4'h0,    32'h1122AB44, 1'b0);
    single(1'b1, 32'h13,   32'h0,        4'h0,    32'hDEADBEEF, 1'b0);
    single(1'b0, 32'h3FFC, 32'h0F0F0F0F, 4'hF,    32'h0,        1'b0);
    single(1'b1, 32'h3FFC, 32'h0,        4'h0,    32'h0F0F0F0F, 1'b0);

    // contention from reset: A first, then strict alternation
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    c0 = cyc;
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h30, 32'h0, 4'h0, 1'b0);
    expect_ack(1'b0, 32'hDEADBEEF, 1'b0, c0 + 2);
    expect_ack(1'b1, 32'h1122AB44, 1'b0, c0 + 5);
    expect_ack(1'b0, 32'hDEADBEEF, 1'b0, c0 + 8);
    expect_ack(1'b1, 32'h1122AB44, 1'b0, c0 + 11);
    tick(11);
    drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
    tick(1);

    // lock: A keeps the memory until its lock drops
    c0 = cyc;
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b1, 32'h30, 32'h0, 4'h0, 1'b0);
    expect_ack(1'b0, 32'hDEADBEEF, 1'b0, c0 + 2);
    expect_ack(1'b0, 32'hDEADBEEF, 1'b0, c0 + 5);
    expect_ack(1'b0, 32'hDEADBEEF, 1'b0, c0 + 8);
    expect_ack(1'b0, 32'hDEADBEEF, 1'b0, c0 + 11);
    expect_ack(1'b1, 32'h1122AB44, 1'b0, c0 + 14);
    tick(8);
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
    tick(6);
    drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
    tick(1);

    // reset during ACCESS: no write, no ack, everything cleared
    single(1'b0, 32'h20, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
    tick(1);
    reset = 1'b1;
    #1;
    check("dwe_in_reset", {28'b0, dwe}, 32'h0);
    tick(1);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
    check_zero("reset_mid");
    check("mem_20_kept", mem[8], 32'h5A5A5A5A);
    single(1'b0, 32'h20, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0);

`ifdef DMEM_ARB_BOUNDS_EN
    single(1'b0, 32'h4000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    check("mem0_kept", mem[0], 32'h0);
    single(1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
`else
    single(1'b0, 32'h4000, 32'h00000077, 4'hF, 32'h0, 1'b0);
    single(1'b1, 32'h0, 32'h0, 4'h0, 32'h00000077, 1'b0);
`endif

    tick(4);
    check("sb_left", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
